// File: rtl/cla_accum.sv
// -----------------------------------------------------------------------------
// cla_accum
//
// Packet accumulator that sits directly downstream of the cla_add
// carry-lookahead adder. It takes the adder's (N+1)-bit unsigned sum through a
// valid/ready handshake and adds every beat of a packet into a wide
// accumulator. When the packet ends it presents the total, the beat count and
// an overflow flag on a registered valid/ready output.
//
// Parameters
//   N        operand width of the upstream cla_add (in_sum is N+1 bits)
//   ACC_W    accumulator width, must be >= N+1
//   COUNT_W  beat-counter width (the count saturates)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_sum / in_last are valid
//   in_ready   a beat is accepted this cycle (depends only on state)
//   in_sum     unsigned sum from cla_add
//   in_last    final beat of the packet
//   out_valid  packet result is valid
//   out_ready  downstream accepts the result
//   out_acc    packet total
//   out_beats  number of beats in the packet, saturating
//   out_ovf    the accumulator overflowed during the packet
//
// Build option
//   CLA_ACCUM_SAT_EN  when defined, the accumulator clamps to all-ones on
//                     overflow and stays clamped for the rest of the packet.
//                     When undefined, it wraps modulo 2^ACC_W. out_ovf flags
//                     the overflow in both builds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cla_accum #(
   parameter int N       = 3,
   parameter int ACC_W   = 8,
   parameter int COUNT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N:0]         in_sum,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_acc,
   output logic [COUNT_W-1:0] out_beats,
   output logic               out_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [COUNT_W-1:0] beats;
   logic               ovf;

   logic               accept;
   logic               handoff;
   logic [ACC_W:0]     sum_wide;
   logic [ACC_W-1:0]   acc_add;
   logic [COUNT_W-1:0] beats_add;

   // The beat counter holds at its maximum rather than wrapping.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      return (c == {COUNT_W{1'b1}}) ? c : c + COUNT_W'(1);
   endfunction

`ifdef CLA_ACCUM_SAT_EN
   // Once the packet has overflowed, the accumulator stays pinned at all-ones.
   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s,
                                                 input logic         sticky);
      return (s[ACC_W] || sticky) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction
`endif

   assign accept  = in_valid && in_ready;
   assign handoff = out_valid && out_ready;

   // One extra bit captures the carry out of the top accumulator bit.
   assign sum_wide = {1'b0, acc} + {{(ACC_W - N){1'b0}}, in_sum};

   always_comb begin
`ifdef CLA_ACCUM_SAT_EN
      acc_add = sat_acc(sum_wide, ovf);
`else
      acc_add = sum_wide[ACC_W-1:0];
`endif
      beats_add = sat_inc(beats);
   end

   // in_ready and out_valid are registered copies of the next state, so
   // in_ready never depends combinationally on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         beats     <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, ACC: begin
               // Raises in_ready on the first edge after reset release.
               in_ready <= 1'b1;
               if (accept) begin
                  acc   <= acc_add;
                  beats <= beats_add;
                  ovf   <= ovf | sum_wide[ACC_W];
                  if (in_last) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            HOLD: begin
               if (handoff) begin
                  state     <= IDLE;
                  acc       <= '0;
                  beats     <= '0;
                  ovf       <= 1'b0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               acc       <= '0;
               beats     <= '0;
               ovf       <= 1'b0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_acc   = acc;
   assign out_beats = beats;
   assign out_ovf   = ovf;

endmodule
